pcs_rx_decoder: RTL and testbench

PCS_RX_DECODER -- requirements
Module: pcs_rx_decoder

---
 rtl/pcs_rx_decoder.sv | 135 +++++++++++++
 tb/tb_pcs_rx_decoder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pcs_rx_decoder.sv
// Receive-side PCS decoder: frames PAM5 code-groups (SSD/ESD delimiters), descrambles
// data bytes with a free-running 33-bit LFSR and flags false carrier / coding errors.
module pcs_rx_decoder #(
    parameter logic [32:0] SEED = 33'h0_0000_0001
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  io_A,
    input  logic [2:0]  io_B,
    input  logic [2:0]  io_C,
    input  logic [2:0]  io_D,
    input  logic        io_mode,
    input  logic        io_loc_rcvr_status,
    output logic [11:0] io_lut_sym,
    input  logic [8:0]  io_lut_sdn,
    input  logic        io_lut_valid,
    output logic [7:0]  io_rx_data,
    output logic        io_rx_dv,
    output logic        io_rx_er,
    output logic [7:0]  io_err_count,
    output logic [2:0]  io_state
);
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SSD2_WAIT   = 3'd1,
        DATA        = 3'd2,
        ESD2_WAIT   = 3'd3,
        CARRIER_EXT = 3'd4
    } state_t;

    localparam logic [2:0]  P2 = 3'b010;
    localparam logic [2:0]  M2 = 3'b110;
    localparam logic [11:0] CG_SSD1    = {P2, P2, P2, P2};
    localparam logic [11:0] CG_SSD2    = {P2, P2, P2, M2};
    localparam logic [11:0] CG_EXT_1   = {P2, P2, M2, P2};
    localparam logic [11:0] CG_EXT_2   = {P2, M2, P2, P2};
    localparam logic [11:0] CG_EXT_ERR = {M2, P2, P2, P2};

    state_t      state_q;
    logic [32:0] lfsr_q, lfsr_d;
    logic [7:0]  rx_data_q, err_count_q;
    logic        rx_dv_q, rx_er_q;
    logic [11:0] sym;
    logic        is_ssd1, is_ssd2, is_ext12, is_ext_err;
    logic        unused_sdn;

    assign sym        = {io_A, io_B, io_C, io_D};
    assign io_lut_sym = sym;
    assign unused_sdn = io_lut_sdn[8];

    assign is_ssd1    = (sym == CG_SSD1);
    assign is_ssd2    = (sym == CG_SSD2);
    assign is_ext12   = (sym == CG_EXT_1) || (sym == CG_EXT_2);
    assign is_ext_err = (sym == CG_EXT_ERR);

    assign lfsr_d = {lfsr_q[31:0], lfsr_q[32] ^ (io_mode ? lfsr_q[12] : lfsr_q[19])};

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            lfsr_q      <= SEED;
            rx_data_q   <= 8'h00;
            rx_dv_q     <= 1'b0;
            rx_er_q     <= 1'b0;
            err_count_q <= 8'h00;
        end else begin
            lfsr_q    <= lfsr_d;
            rx_data_q <= 8'h00;
            rx_dv_q   <= 1'b0;
            rx_er_q   <= 1'b0;
            // Loss of receiver lock silently drops any frame in progress.
            if (!io_loc_rcvr_status) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: if (is_ssd1) state_q <= SSD2_WAIT;
                    SSD2_WAIT: begin
                        if (is_ssd2) begin
                            state_q <= DATA;
                        end else begin
                            state_q     <= IDLE;
                            rx_er_q     <= 1'b1;
                            rx_data_q   <= 8'h0E;
                            err_count_q <= sat_inc(err_count_q);
                        end
                    end
                    DATA: begin
                        if (is_ssd1) begin
                            state_q <= ESD2_WAIT;
                        end else if (io_lut_valid) begin
                            rx_dv_q   <= 1'b1;
                            rx_data_q <= io_lut_sdn[7:0] ^ lfsr_q[7:0];
                        end else begin
                            rx_dv_q     <= 1'b1;
                            rx_er_q     <= 1'b1;
                            err_count_q <= sat_inc(err_count_q);
                        end
                    end
                    ESD2_WAIT: begin
                        if (is_ssd2) begin
                            state_q <= IDLE;
                        end else if (is_ext12 || is_ext_err) begin
                            state_q   <= CARRIER_EXT;
                            rx_er_q   <= 1'b1;
                            rx_data_q <= is_ext_err ? 8'h1F : 8'h0F;
                        end else begin
                            state_q     <= IDLE;
                            rx_er_q     <= 1'b1;
                            err_count_q <= sat_inc(err_count_q);
                        end
                    end
                    CARRIER_EXT: begin
                        if (is_ext12 || is_ext_err) begin
                            rx_er_q   <= 1'b1;
                            rx_data_q <= is_ext_err ? 8'h1F : 8'h0F;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign io_rx_data   = rx_data_q;
    assign io_rx_dv     = rx_dv_q;
    assign io_rx_er     = rx_er_q;
    assign io_err_count = err_count_q;
    assign io_state     = state_q;
endmodule

// File: tb/tb_pcs_rx_decoder.sv
// Randomized bench for pcs_rx_decoder: a frame-level model with a scrambler bit-history
// predicts every output each cycle; directed frames pin the model to literal values.
module tb_pcs_rx_decoder;
    logic        clock = 1'b0;
    logic        rst_n;
    logic [2:0]  a_in, b_in, c_in, d_in;
    logic        mode, rcv;
    logic [11:0] lut_sym;
    logic [8:0]  sdn;
    logic        lvalid;
    logic [7:0]  rx_data, err_count;
    logic        rx_dv, rx_er;
    logic [2:0]  state;

    int checks = 0;
    int failures = 0;

    pcs_rx_decoder #(.SEED(33'h0_0000_0001)) dut (
        .clock(clock), .reset(rst_n),
        .io_A(a_in), .io_B(b_in), .io_C(c_in), .io_D(d_in),
        .io_mode(mode), .io_loc_rcvr_status(rcv),
        .io_lut_sym(lut_sym), .io_lut_sdn(sdn), .io_lut_valid(lvalid),
        .io_rx_data(rx_data), .io_rx_dv(rx_dv), .io_rx_er(rx_er),
        .io_err_count(err_count), .io_state(state)
    );

    always #5 clock = ~clock;

    // Model: scrambler kept as a bit history; lfsr[i] at sample k is lb[lp-i].
    bit   lb [0:40000];
    int   lp;
    int   mst;        // 0 idle, 1 expect SSD2, 2 in frame, 3 expect ESD2, 4 extending
    int   e_err;
    logic [7:0] e_data;
    logic e_dv, e_er;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // 1 SSD1/ESD1, 2 SSD2/Ext0, 3 Ext1, 4 Ext2, 5 ExtErr, 0 other
    function automatic int cls(input int a, input int b, input int c, input int d);
        if (a == 2 && b == 2 && c == 2 && d == 2)  return 1;
        if (a == 2 && b == 2 && c == 2 && d == -2) return 2;
        if (a == 2 && b == 2 && c == -2 && d == 2) return 3;
        if (a == 2 && b == -2 && c == 2 && d == 2) return 4;
        if (a == -2 && b == 2 && c == 2 && d == 2) return 5;
        return 0;
    endfunction

    function automatic int sv3(input logic [2:0] x);
        return int'($signed(x));
    endfunction

    task automatic model_edge();
        logic [7:0] sc;
        int g;
        if (!rst_n) begin
            mst = 0; e_err = 0; e_dv = 0; e_er = 0; e_data = 8'h00; lp = 32;
            return;
        end
        for (int i = 0; i < 8; i++) sc[i] = lb[lp - i];
        g = cls(sv3(a_in), sv3(b_in), sv3(c_in), sv3(d_in));
        e_dv = 0; e_er = 0; e_data = 8'h00;
        if (!rcv) mst = 0;
        else if (mst == 0) begin
            if (g == 1) mst = 1;
        end else if (mst == 1) begin
            if (g == 2) mst = 2;
            else begin mst = 0; e_er = 1; e_data = 8'h0E; e_err++; end
        end else if (mst == 2) begin
            if (g == 1) mst = 3;
            else if (lvalid) begin e_dv = 1; e_data = sdn[7:0] ^ sc; end
            else begin e_dv = 1; e_er = 1; e_err++; end
        end else begin
            if (mst == 3 && g == 2) mst = 0;
            else if (g >= 3) begin mst = 4; e_er = 1; e_data = (g == 5) ? 8'h1F : 8'h0F; end
            else if (mst == 3) begin mst = 0; e_er = 1; e_err++; end
            else mst = 0;
        end
        if (e_err > 255) e_err = 255;
        lb[lp + 1] = lb[lp - 32] ^ lb[lp - (mode ? 12 : 19)];
        lp++;
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        chk("rx_data", rx_data, e_data);
        chk("rx_dv", rx_dv, e_dv);
        chk("rx_er", rx_er, e_er);
        chk("err_count", err_count, e_err);
        chk("state", state, mst);
    endtask

    task automatic send(input int a, input int b, input int c, input int d,
                        input bit v = 1'b1, input logic [8:0] s = 9'h0A5);
        a_in = 3'(a); b_in = 3'(b); c_in = 3'(c); d_in = 3'(d);
        lvalid = v; sdn = s;
        step();
    endtask

    int r;
    initial begin
        for (int i = 0; i <= 32; i++) lb[32 - i] = (i == 0);
        lp = 32; mst = 0; e_err = 0; e_dv = 0; e_er = 0; e_data = 0;
        rst_n = 0; mode = 0; rcv = 1; lvalid = 0; sdn = 0;
        a_in = 0; b_in = 0; c_in = 0; d_in = 0;
        #2;
        repeat (4) step();
        rst_n = 1;
        chk("rst_state", state, 0);
        chk("rst_err", err_count, 0);
        chk("rst_dv", rx_dv, 0);

        // Good frame: bytes descrambled with Sc = 4, 8, 16
        send(2, 2, 2, 2); send(2, 2, 2, -2);
        send(0, 1, -1, 0); chk("frame_b0", rx_data, 8'hA1);
        send(1, 0, 0, 0);  chk("frame_b1", rx_data, 8'hAD);
        send(0, 0, 1, -1); chk("frame_b2", rx_data, 8'hB5);
        send(2, 2, 2, 2); send(2, 2, 2, -2);
        chk("frame_end_state", state, 0);
        chk("frame_end_err", err_count, 0);

        // False carrier
        send(2, 2, 2, 2); send(0, 0, 0, 0);
        chk("fc_data", rx_data, 8'h0E);
        chk("fc_er", rx_er, 1);
        chk("fc_err", err_count, 1);

        // Invalid data group
        send(2, 2, 2, 2); send(2, 2, 2, -2); send(0, 0, 0, 0, 1'b0);
        chk("bad_data", rx_data, 8'h00);
        chk("bad_er", rx_er, 1);
        chk("bad_err", err_count, 2);
        chk("bad_state", state, 2);

        // Carrier extension sequence
        send(2, 2, 2, 2);
        send(2, 2, -2, 2); chk("ext1", rx_data, 8'h0F);
        send(2, -2, 2, 2); chk("ext2a", rx_data, 8'h0F);
        send(2, -2, 2, 2); chk("ext2b", rx_data, 8'h0F);
        send(-2, 2, 2, 2); chk("exterr", rx_data, 8'h1F);
        send(0, 0, 0, 0);
        chk("ext_done_er", rx_er, 0);
        chk("ext_done_state", state, 0);

        // Receiver drop mid-frame, then saturate the counter
        send(2, 2, 2, 2); send(2, 2, 2, -2); send(1, 1, 1, 1);
        rcv = 0; send(1, 1, 1, 1);
        chk("rcv_dv", rx_dv, 0);
        chk("rcv_state", state, 0);
        rcv = 1;
        repeat (300) begin send(2, 2, 2, 2); send(0, 0, 0, 0); end
        chk("sat_err", err_count, 255);

        // Randomized traffic, with mode, receiver-status and reset disturbances
        rst_n = 0; step(); rst_n = 1;
        for (int n = 0; n < 4000; n++) begin
            mode = ($urandom_range(0, 199) == 0) ? ~mode : mode;
            rcv  = ($urandom_range(0, 59) != 0);
            rst_n = ($urandom_range(0, 299) != 0);
            r = $urandom_range(0, 11);
            case (r)
                0, 1: send(2, 2, 2, 2, 1'($urandom), 9'($urandom));
                2, 3: send(2, 2, 2, -2, 1'($urandom), 9'($urandom));
                4:    send(2, 2, -2, 2, 1'($urandom), 9'($urandom));
                5:    send(2, -2, 2, 2, 1'($urandom), 9'($urandom));
                6:    send(-2, 2, 2, 2, 1'($urandom), 9'($urandom));
                default:
                    send($urandom_range(0, 4) - 2, $urandom_range(0, 4) - 2,
                         $urandom_range(0, 4) - 2, $urandom_range(0, 4) - 2,
                         ($urandom_range(0, 7) != 0), 9'($urandom));
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
